// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// One word access is accepted from IDLE and acknowledged LATENCY cycles later.
// Optional build macro: MISALIGN_CHECK_EN. When it is defined, a request with
// addr_i[1:0] != 0 acks with err_o=1, does not write, and loads 0.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            mis_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            mis_in_c;
    logic            acc_c;
    logic            acc_we_c;
    logic [AW-1:0]   acc_idx_c;
    logic [31:0]     acc_wdata_c;
    logic            acc_mis_c;
    logic            unused_addr_c;

    // Address bits above the memory size wrap; low bits only matter for the misalign check
    assign unused_addr_c = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef MISALIGN_CHECK_EN
    assign mis_in_c = (addr_i[1:0] != 2'b00);
`else
    assign mis_in_c = 1'b0;
`endif

    // The CPU waits whenever it has a request that is not being acknowledged this cycle
    assign stall_o = req_i & ~ack_o;

    // Select the access performed at this edge: live inputs when LATENCY==1, latched otherwise
    always_comb begin
        acc_c       = 1'b0;
        acc_we_c    = we_q;
        acc_idx_c   = idx_q;
        acc_wdata_c = wdata_q;
        acc_mis_c   = mis_q;
        if (state == IDLE) begin
            acc_we_c    = we_i;
            acc_idx_c   = addr_i[AW+1:2];
            acc_wdata_c = wdata_i;
            acc_mis_c   = mis_in_c;
            acc_c       = req_i && (LATENCY == 1);
        end else if (state == WAIT) begin
            acc_c = (cnt == CW'(1));
        end
    end

    // Memory array write port; not reset, and a store in flight at reset never lands
    always_ff @(posedge clk_i) begin
        if (acc_c && acc_we_c && !acc_mis_c && rst_i) begin
            mem[acc_idx_c] <= acc_wdata_c;
        end
    end

    // Request FSM with registered ack/busy/err/rdata
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_o   <= 1'b0;
            rdata_o <= '0;
            busy_o  <= 1'b0;
            err_o   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (acc_c) begin
                ack_o <= 1'b1;
                err_o <= acc_mis_c;
                if (!acc_we_c) begin
                    rdata_o <= acc_mis_c ? 32'h0 : mem[acc_idx_c];
                end
            end
            case (state)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_i[AW+1:2];
                        wdata_q <= wdata_i;
                        mis_q   <= mis_in_c;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? DONE : WAIT;
                        busy_o  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus random traffic against a word-array model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 4;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        busy_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [int unsigned];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: word-addressed array; misaligned access is an error only with the check enabled
    function automatic void model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] exp_rd, output logic exp_err);
        int unsigned idx;
        idx     = (addr / 4) % DEPTH;
        exp_err = MIS_EN && ((addr % 4) != 0);
        exp_rd  = 32'h0;
        if (we) begin
            if (!exp_err) model[idx] = wd;
        end else if (!exp_err) begin
            exp_rd = model.exists(idx) ? model[idx] : 32'hxxxxxxxx;
        end
    endfunction

    // One request; checks stall/busy/ack cycle by cycle (cycle 0 = the cycle req rises)
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        bit got;
        got = 0;
        rd  = 32'h0;
        er  = 1'b0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
        for (int cyc = 0; cyc < int'(LAT) + 4 && !got; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            #1;
            chk("stall", 32'(stall_o), 32'(cyc < int'(LAT)));
            chk("busy", 32'(busy_o), 32'(cyc >= 1));
            chk("ack", 32'(ack_o), 32'(cyc == int'(LAT)));
            if (ack_o === 1'b1) begin
                got = 1;
                rd  = rdata_o;
                er  = err_o;
            end
        end
        req_i = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        er;
        model_access(we, addr, wd, exp_rd, exp_err);
        access(we, addr, wd, rd, er);
        chk("err", 32'(er), 32'(exp_err));
        if (!we) chk("rdata", rd, exp_rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] pool [8];
        int unsigned sel;
        logic [31:0] a;

        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Store then load at 0x10, rdata held afterwards
        txn(1'b1, 32'h10, 32'hDEADBEEF, rd);
        txn(1'b0, 32'h10, 32'h0, rd);
        chk("load_deadbeef", rd, 32'hDEADBEEF);
        repeat (10) @(negedge clk_i);
        #1;
        chk("rdata_hold", rdata_o, 32'hDEADBEEF);
        chk("idle_ack", 32'(ack_o), 32'd0);

        // Back-to-back loads with req held high
        txn(1'b1, 32'h14, 32'h0, rd);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            chk("b2b_ack", 32'(ack_o), 32'((c == 4) || (c == 9)));
            chk("b2b_stall", 32'(stall_o), 32'((c < 9) && (c != 4)));
            chk("b2b_busy", 32'(busy_o), 32'(((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9))));
            if (c == 4) begin
                chk("b2b_rd0", rdata_o, 32'hDEADBEEF);
                addr_i = 32'h14;
            end
            if (c == 9) begin
                chk("b2b_rd1", rdata_o, 32'h0);
                req_i = 1'b0;
            end
        end

        // Reset in the middle of a store drops it
        txn(1'b1, 32'h20, 32'h0BADF00D, rd);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            chk("rst_mid_ack", 32'(ack_o), 32'd0);
        end
        @(negedge clk_i);
        #1;
        rst_i = 1'b0; req_i = 1'b0;
        #1;
        chk("rst_mid_ack0", 32'(ack_o), 32'd0);
        chk("rst_mid_busy0", 32'(busy_o), 32'd0);
        chk("rst_mid_rdata0", rdata_o, 32'd0);
        chk("rst_mid_err0", 32'(err_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            #1;
            chk("rst_mid_noack", 32'(ack_o), 32'd0);
        end
        txn(1'b0, 32'h20, 32'h0, rd);
        chk("rst_old_value", rd, 32'h0BADF00D);

        // Address wrap
        txn(1'b1, 32'h400, 32'hCAFEF00D, rd);
        txn(1'b0, 32'h000, 32'h0, rd);
        chk("wrap_load", rd, 32'hCAFEF00D);

        // Misaligned store
        txn(1'b1, 32'h10, 32'h11112222, rd);
        txn(1'b1, 32'h13, 32'hAAAA5555, rd);
        txn(1'b0, 32'h10, 32'h0, rd);
        chk("misalign_load", rd, MIS_EN ? 32'h11112222 : 32'hAAAA5555);

        // Random traffic over a pool of words, with random wrap and low address bits
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'($urandom_range(DEPTH - 1, 0));
            txn(1'b1, pool[i] << 2, $urandom, rd);
        end
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(7, 0);
            a   = ($urandom & 32'hFFFF_FC00) | (pool[sel] << 2);
            if ($urandom_range(3, 0) == 0) a = a | 32'($urandom_range(3, 0));
            txn(1'($urandom_range(1, 0)), a, $urandom, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
